d_cache_wb_buffer: RTL and testbench
====================================

// Module: d_cache_wb_buffer
// PURPOSE
//  Parametrised write-back buffer between the data cache and the AXI write channel.
//  The cache pushes a whole dirty victim line in one cycle and continues its refill without waiting for the write.
//  The buffer drains queued lines in FIFO order as INCR bursts.
//  Adjacent pushes to the same line coalesce. A combinational lookup port lets the cache forward data for
//  a refill or load that targets a line still in the buffer.
// PARAMETERS
//  DEPTH         4    number of line entries; power of 2, >=2
//  LINE_WORDS    8    32-bit words per line; power of 2, burst length
//  OFFSET_WIDTH  5    byte-offset bits of a line; must equal log2(LINE_WORDS)+2
// PORTS
//  clk           in   1                 clock, all state on rising edge
//  rst           in   1                 asynchronous reset, active low
//  push_valid    in   1                 victim line offered
//  push_ready    out  1                 buffer accepts push this cycle
//  push_addr     in   32                victim address; bits [OFFSET_WIDTH-1:0] ignored
//  push_line     in   32*LINE_WORDS     line data; word i at bits [32*i+31:32*i]
//  lookup_addr   in   32                byte address to search
//  lookup_hit    out  1                 a resident entry holds lookup_addr's line
//  lookup_data   out  32                word lookup_addr[OFFSET_WIDTH-1:2] of the youngest matching entry
//  empty         out  1                 no entries resident
//  awaddr        out  32                {line addr, OFFSET_WIDTH'b0} of head entry
//  awlen         out  8                 LINE_WORDS-1, constant
//  awsize        out  3                 3'b010, constant
//  awvalid       out  1                 write address valid
//  awready       in   1                 write address ready
//  wdata         out  32                head entry word[beat]
//  wstrb         out  4                 4'b1111, constant
//  wlast         out  1                 beat == LINE_WORDS-1 while wvalid
//  wvalid        out  1                 write data valid
//  wready        in   1                 write data ready
//  bvalid        in   1                 write response valid
//  bready        out  1                 write response ready
// BEHAVIOUR
//  Reset (rst low)
//   - Takes effect immediately; no clock edge needed.
//   - Clears all entries, pointers, count, beat counter and FSM.
//   - Outputs during and after reset: awvalid=0, wvalid=0, bready=0, empty=1, push_ready=1, lookup_hit=0.
//   - Reset mid-burst abandons the burst. The interconnect is reset alongside.
//  Storage
//   - Circular FIFO with head, tail and count (log2(DEPTH)+1 bits).
//   - Pointers wrap modulo DEPTH.
//   - Each entry holds a valid bit, line address [31:OFFSET_WIDTH] and LINE_WORDS data words.
//  Push
//   - Handshake is push_valid & push_ready at the clock edge.
//   - Coalesce: if push_addr's line matches the youngest valid entry and that entry is not locked,
//     overwrite its data in place. Count is unchanged.
//   - Otherwise allocate at tail; tail+1, count+1.
//   - push_ready = (count<DEPTH) | coalesce_match. A pop in the same cycle does NOT free a slot for the push.
//   - Simultaneous push and pop: both apply; count += alloc - pop.
//  Drain FSM (IDLE, AW, W, B)
//   - IDLE -> AW when count!=0. The head entry becomes locked and stays locked until popped.
//   - AW: awvalid=1; hold awaddr stable until awready. -> W on awvalid&awready.
//   - W: wvalid=1. Beat advances on wvalid&wready. wvalid is never asserted before the AW handshake.
//     -> B on the wlast handshake; beat returns to 0.
//   - B: bready=1. On bvalid: pop head (valid=0, head+1, count-1) -> IDLE.
//   - No response check; BRESP is not examined.
//  Latency
//   - Push into an empty buffer at edge t gives awvalid=1 in cycle t+1.
//   - Back-to-back entries leave one IDLE cycle between B and the next AW.
//  Lookup
//   - Purely combinational over all valid entries, including a locked head being drained.
//   - If several entries match, the youngest (nearest tail) wins.
//   - A push in the same cycle is not visible until the next cycle.
//  empty = (count==0). A full buffer with a non-matching push holds push_ready low until a pop has been registered.
// TESTING
//  1. Reset, then push line 0x0000_1000 with words k=0..7 = 0xA0+k, awready=wready=bvalid=1.
//     -> awvalid in the next cycle with awaddr=0x1000, awlen=7; 8 beats 0xA0..0xA7; wlast on beat 7; empty=1 after B.
//  2. Push 0x2000 (data X), then 0x2000 (data Y) while awready=0.
//     -> Head is locked, so the second push allocates (count=2).
//     -> lookup 0x2004 returns Y[1]; bursts go out X then Y.
//  3. Hold awready=0 and push 0x3000 then 0x3000 again with new data before IDLE->AW.
//     -> The second push coalesces (count=1); a single burst carries the new data.
//  4. Fill DEPTH=4 entries with awready=0; offer a 5th distinct line.
//     -> push_ready=0 until the cycle after the first B handshake; the FIFO order of the four bursts is preserved.
//  5. Assert rst low during W beat 3.
//     -> wvalid/awvalid/bready fall immediately; after release empty=1, lookup_hit=0, no further AW.
//  6. Apply random wready/bvalid stall patterns over 200 pushes.
//     -> Every accepted non-coalesced line appears exactly once on AXI in push order with its last-written data.

Source files
------------

// File: rtl/d_cache_wb_buffer.sv
// Write-back buffer: queues dirty victim lines from the cache and drains them as AXI INCR bursts,
// coalescing a repeat push to the youngest unlocked line and forwarding resident data to lookups.
module d_cache_wb_buffer #(
  parameter int DEPTH        = 4,
  parameter int LINE_WORDS   = 8,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [31:0]             push_addr,
  input  logic [32*LINE_WORDS-1:0] push_line,
  input  logic [31:0]             lookup_addr,
  output logic                    lookup_hit,
  output logic [31:0]             lookup_data,
  output logic                    empty,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LA_W   = 32 - OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    head, tail, youngest, widx, lk_idx;
  logic [CNT_W-1:0]    count;
  logic [BEAT_W-1:0]   beat;
  logic [DEPTH-1:0]    valid;
  logic [LA_W-1:0]     line_addr [DEPTH];
  logic [31:0]         data [DEPTH][LINE_WORDS];
  logic                coalesce, push_fire, alloc, pop, w_fire, last_beat;
  logic                unused_bits;

  assign unused_bits = ^{push_addr[OFFSET_WIDTH-1:0], lookup_addr[1:0]};

  // The head is locked whenever the drain FSM has left IDLE; it is the youngest only when count is 1.
  assign youngest  = tail - PTR_W'(1);
  assign coalesce  = (count != '0) && valid[youngest] &&
                     (line_addr[youngest] == push_addr[31:OFFSET_WIDTH]) &&
                     !((state != IDLE) && (count == CNT_W'(1)));
  assign push_ready = (count < CNT_W'(DEPTH)) | coalesce;
  assign push_fire  = push_valid & push_ready;
  assign alloc      = push_fire & ~coalesce;
  assign widx       = coalesce ? youngest : tail;
  assign empty      = (count == '0);

  assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));
  assign w_fire    = wvalid & wready;
  assign pop       = bready & bvalid;

  assign awaddr = {line_addr[head], {OFFSET_WIDTH{1'b0}}};
  assign awlen  = 8'(LINE_WORDS - 1);
  assign awsize = 3'b010;
  assign wdata  = data[head][beat];
  assign wstrb  = 4'b1111;
  assign wlast  = wvalid & last_beat;

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: if (count != '0) state_nxt = AW;
      AW: begin
        awvalid = 1'b1;
        if (awready) state_nxt = W;
      end
      W: begin
        wvalid = 1'b1;
        if (wready && last_beat) state_nxt = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      beat  <= '0;
      valid <= '0;
    end else begin
      state <= state_nxt;
      if (w_fire) beat <= last_beat ? '0 : beat + BEAT_W'(1);
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  // Payload needs no reset: every read of it is qualified by a valid bit.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      line_addr[widx] <= push_addr[31:OFFSET_WIDTH];
      for (int w = 0; w < LINE_WORDS; w++) data[widx][w] <= push_line[32*w +: 32];
    end
  end

  // Scan oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head + PTR_W'(i);
      if (valid[lk_idx] && (line_addr[lk_idx] == lookup_addr[31:OFFSET_WIDTH])) begin
        lookup_hit  = 1'b1;
        lookup_data = data[lk_idx][lookup_addr[OFFSET_WIDTH-1:2]];
      end
    end
  end

endmodule

// File: tb/tb_d_cache_wb_buffer.sv
// Directed and random stimulus for d_cache_wb_buffer; an AXI-side monitor checks bursts against a scoreboard queue.
module tb_d_cache_wb_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         push_valid, push_ready;
  logic [31:0]  push_addr;
  logic [255:0] push_line;
  logic [31:0]  lookup_addr, lookup_data;
  logic         lookup_hit, empty;
  logic [31:0]  awaddr, wdata;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
  } burst_t;

  burst_t exq[$];
  burst_t cur;
  int     checks = 0;
  int     failures = 0;
  int     bursts = 0;
  int     allocs = 0;
  int     mon_beat = 0;
  bit     mon_in_burst = 0;
  bit     stall_on = 0;

  d_cache_wb_buffer dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr), .push_line(push_line),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data), .empty(empty),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic do_push(input logic [31:0] a, input logic [255:0] d, input bit coal);
    int n = 0;
    push_valid = 1'b1;
    push_addr  = a;
    push_line  = d;
    @(negedge clk);
    while (!push_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 32'(n < 2000), 1);
    @(posedge clk);
    #1 push_valid = 1'b0;
    if (coal) exq[exq.size()-1].line = d;
    else begin
      exq.push_back('{a & ~32'h1F, d});
      allocs++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(empty && exq.size() == 0 && !mon_in_burst) && n < 20000);
    chk(tag, 32'(n < 20000), 1);
    @(posedge clk);
    #1;
  endtask

  // Handshakes are judged at the falling edge; inputs only move just after rising edges.
  always @(negedge clk) begin
    if (!rst) begin
      mon_in_burst = 0;
      mon_beat     = 0;
    end else begin
      if (awvalid && awready) begin
        chk("aw_expected", 32'(exq.size() > 0), 1);
        if (exq.size() > 0) begin
          cur = exq.pop_front();
          chk("awaddr", awaddr, cur.addr);
          chk("awlen", 32'(awlen), 7);
          chk("awsize", 32'(awsize), 2);
        end
        bursts++;
        mon_in_burst = 1;
        mon_beat     = 0;
      end
      if (wvalid && wready) begin
        chk("w_after_aw", 32'(mon_in_burst), 1);
        chk("wdata", wdata, cur.line[32*mon_beat +: 32]);
        chk("wlast", 32'(wlast), 32'(mon_beat == 7));
        chk("wstrb", 32'(wstrb), 32'hF);
        if (mon_beat == 7) mon_in_burst = 0;
        mon_beat = (mon_beat + 1) % 8;
      end
    end
  end

  initial begin
    logic [255:0] d;
    int k, n, b0;
    bit seen_b;
    rst = 1'b1; push_valid = 0; push_addr = 0; push_line = 0; lookup_addr = 32'h1000;
    awready = 0; wready = 0; bvalid = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_lookup_hit", 32'(lookup_hit), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single line, free-flowing AXI
    awready = 1; wready = 1; bvalid = 1;
    do_push(32'h0000_1000, mk(32'hA0), 0);
    @(negedge clk);
    chk("t1_idle_gap", 32'(awvalid), 0);
    @(negedge clk);
    chk("t1_awvalid", 32'(awvalid), 1);
    chk("t1_awaddr", awaddr, 32'h1000);
    wait_idle("t1_drain");
    chk("t1_empty", 32'(empty), 1);

    // locked head forces a second allocation for the same line
    awready = 0;
    do_push(32'h0000_2000, mk(32'hB0), 0);
    @(posedge clk);
    #1;
    do_push(32'h0000_2000, mk(32'hC0), 0);
    lookup_addr = 32'h0000_2004;
    #1;
    chk("t2_hit", 32'(lookup_hit), 1);
    chk("t2_data", lookup_data, 32'hC1);
    lookup_addr = 32'h0000_7000;
    #1;
    chk("t2_miss", 32'(lookup_hit), 0);
    awready = 1;
    wait_idle("t2_drain");

    // back-to-back pushes before the drain starts coalesce
    awready = 0;
    do_push(32'h0000_3000, mk(32'hD0), 0);
    do_push(32'h0000_3004, mk(32'hE0), 1);
    lookup_addr = 32'h0000_3008;
    #1;
    chk("t3_hit", 32'(lookup_hit), 1);
    chk("t3_data", lookup_data, 32'hE2);
    awready = 1;
    wait_idle("t3_drain");

    // full buffer blocks a fifth distinct line until the first pop
    awready = 0;
    for (int i = 0; i < 4; i++) do_push(32'h0000_4000 + 32'(i * 32), mk(32'h400 + 32'(i * 16)), 0);
    push_valid = 1; push_addr = 32'h0000_4080; push_line = mk(32'h480);
    awready = 1; wready = 1; bvalid = 1;
    seen_b = 0;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      chk("t4_push_ready", 32'(push_ready), 32'(seen_b));
      if (push_ready) break;
      if (bvalid && bready) seen_b = 1;
      n++;
    end
    chk("t4_timeout", 32'(n < 500), 1);
    @(posedge clk);
    #1 push_valid = 0;
    exq.push_back('{32'h0000_4080, mk(32'h480)});
    allocs++;
    wait_idle("t4_drain");

    // reset in the middle of a burst
    bvalid = 0;
    do_push(32'h0000_5000, mk(32'h50), 0);
    k = 0;
    n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      if (wvalid && wready) k++;
      n++;
    end
    chk("t5_beats", 32'(k), 3);
    @(posedge clk);
    #2;
    chk("t5_pre_wvalid", 32'(wvalid), 1);
    rst = 1'b0;
    exq.delete();
    b0 = bursts;
    #1;
    chk("t5_wvalid", 32'(wvalid), 0);
    chk("t5_awvalid", 32'(awvalid), 0);
    chk("t5_bready", 32'(bready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    lookup_addr = 32'h0000_5000;
    #1;
    chk("t5_empty", 32'(empty), 1);
    chk("t5_lookup", 32'(lookup_hit), 0);
    repeat (20) @(negedge clk);
    chk("t5_no_aw", 32'(awvalid), 0);
    chk("t5_bursts", 32'(bursts), 32'(b0));
    bvalid = 1;
    @(posedge clk);
    #1;

    // random stalls over 200 distinct lines
    stall_on = 1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
          do_push(32'h0010_0000 + 32'(i * 32), d, 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        stall_on = 0;
      end
      begin
        while (stall_on) begin
          @(posedge clk);
          #1;
          awready = ($urandom_range(0, 3) != 0);
          wready  = ($urandom_range(0, 2) != 0);
          bvalid  = ($urandom_range(0, 2) != 0);
        end
      end
    join
    awready = 1; wready = 1; bvalid = 1;
    wait_idle("t6_drain");
    chk("t6_queue", 32'(exq.size()), 0);
    chk("burst_total", 32'(bursts), 32'(allocs));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
